// File: rtl/zynq_axi_mem_responder_if.sv
// AXI4 slave-side signal bundle used by zynq_axi_mem_responder (INCR, full-width bursts).
interface zynq_axi_mem_responder_if #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32,
    parameter int id_width_p   = 6
);
    logic [addr_width_p-1:0]   awaddr;
    logic [id_width_p-1:0]     awid;
    logic [7:0]                awlen;
    logic                      awvalid;
    logic                      awready;
    logic [data_width_p-1:0]   wdata;
    logic [data_width_p/8-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic [id_width_p-1:0]     bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [addr_width_p-1:0]   araddr;
    logic [id_width_p-1:0]     arid;
    logic [7:0]                arlen;
    logic                      arvalid;
    logic                      arready;
    logic [data_width_p-1:0]   rdata;
    logic [id_width_p-1:0]     rid;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awaddr, awid, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  araddr, arid, arlen, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rdata, rid, rresp, rlast, rvalid
    );

    modport master (
        output awaddr, awid, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output araddr, arid, arlen, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rdata, rid, rresp, rlast, rvalid
    );
endinterface

// File: rtl/zynq_axi_mem_responder.sv
// AXI4 memory responder with independent read/write burst FSMs over a word-wide RAM.
// Define ZYNQ_AXI_MEM_BOUNDS_CHECK_EN to flag out-of-range beats as SLVERR instead of wrapping.
module zynq_axi_mem_responder #(
    parameter int                     data_width_p = 32,
    parameter int                     addr_width_p = 32,
    parameter int                     id_width_p   = 6,
    parameter int                     els_p        = 1024,
    parameter logic [addr_width_p-1:0] base_addr_p = '0
) (
    input logic aclk,
    input logic aresetn,
    zynq_axi_mem_responder_if.slave s_axi
);
    localparam int bytes_lp = data_width_p / 8;
    localparam int off_lp   = $clog2(bytes_lp);
    localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [addr_width_p-1:0] step_lp = addr_width_p'(bytes_lp);
    localparam logic [addr_width_p-1:0] els_lp  = addr_width_p'(els_p);
    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;

`ifdef ZYNQ_AXI_MEM_BOUNDS_CHECK_EN
    localparam bit bounds_en_lp = 1'b1;
`else
    localparam bit bounds_en_lp = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    function automatic logic [addr_width_p-1:0] word_of(input logic [addr_width_p-1:0] a);
        return (a - base_addr_p) >> off_lp;
    endfunction

    // In-range words map identically under modulo, so one index path serves both builds.
    function automatic logic [idx_w_lp-1:0] idx_of(input logic [addr_width_p-1:0] a);
        return idx_w_lp'(word_of(a) % els_lp);
    endfunction

    function automatic logic err_of(input logic [addr_width_p-1:0] a);
        return bounds_en_lp && (word_of(a) >= els_lp);
    endfunction

    logic [data_width_p-1:0] mem_q [els_p];

    // ---------------- write channel ----------------
    w_state_e                w_state_q, w_state_d;
    logic [id_width_p-1:0]   bid_q;
    logic [addr_width_p-1:0] waddr_q;
    logic [7:0]              wlen_q, wbeat_q;
    logic                    werr_q;
    logic                    aw_fire, w_fire, b_fire, w_beat_err;
    logic                    unused_wlast;

    assign s_axi.awready = aresetn && (w_state_q == W_IDLE);
    assign s_axi.wready  = aresetn && (w_state_q == W_DATA);
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = werr_q ? resp_slverr_lp : resp_okay_lp;

    assign aw_fire      = s_axi.awvalid && s_axi.awready;
    assign w_fire       = s_axi.wvalid && s_axi.wready;
    assign b_fire       = s_axi.bvalid && s_axi.bready;
    assign w_beat_err   = err_of(waddr_q);
    assign unused_wlast = s_axi.wlast;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (aw_fire) w_state_d = W_DATA;
            W_DATA:  if (w_fire && (wbeat_q == wlen_q)) w_state_d = W_RESP;
            W_RESP:  if (b_fire) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_fire) begin
                bid_q   <= s_axi.awid;
                waddr_q <= s_axi.awaddr;
                wlen_q  <= s_axi.awlen;
                wbeat_q <= '0;
                werr_q  <= 1'b0;
            end else if (w_fire) begin
                waddr_q <= waddr_q + step_lp;
                wbeat_q <= wbeat_q + 8'd1;
                werr_q  <= werr_q | w_beat_err;
            end
        end
    end

    // NOTE: the storage array is deliberately left out of reset; only control state is cleared.
    always_ff @(posedge aclk) begin
        if (w_fire && !w_beat_err) begin
            for (int b = 0; b < bytes_lp; b++) begin
                if (s_axi.wstrb[b]) mem_q[idx_of(waddr_q)][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e                r_state_q, r_state_d;
    logic [id_width_p-1:0]   rid_q;
    logic [addr_width_p-1:0] raddr_q;
    logic [7:0]              rlen_q, rbeat_q;
    logic [data_width_p-1:0] rdata_q;
    logic [1:0]              rresp_q;
    logic                    rlast_q;
    logic                    ar_fire, r_fire, r_load, r_err;
    logic [addr_width_p-1:0] r_src_addr;

    assign s_axi.arready = aresetn && (r_state_q == R_IDLE);
    assign s_axi.rvalid  = (r_state_q == R_DATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;

    assign ar_fire    = s_axi.arvalid && s_axi.arready;
    assign r_fire     = s_axi.rvalid && s_axi.rready;
    // A new beat is fetched on the AR handshake and after every non-final R handshake.
    assign r_load     = ar_fire || (r_fire && !rlast_q);
    assign r_src_addr = ar_fire ? s_axi.araddr : raddr_q;
    assign r_err      = err_of(r_src_addr);

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (ar_fire) r_state_d = R_DATA;
            R_DATA:  if (r_fire && rlast_q) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= resp_okay_lp;
            rlast_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_fire) begin
                rid_q   <= s_axi.arid;
                rlen_q  <= s_axi.arlen;
                rbeat_q <= '0;
                rlast_q <= (s_axi.arlen == 8'd0);
            end else if (r_fire) begin
                rbeat_q <= rbeat_q + 8'd1;
                rlast_q <= !rlast_q && ((rbeat_q + 8'd1) == rlen_q);
            end
            if (r_load) begin
                raddr_q <= r_src_addr + step_lp;
                rdata_q <= r_err ? '0 : mem_q[idx_of(r_src_addr)];
                rresp_q <= r_err ? resp_slverr_lp : resp_okay_lp;
            end
        end
    end
endmodule

// File: tb/tb_zynq_axi_mem_responder.sv
// Randomized bench for zynq_axi_mem_responder against a word-array memory model with response queues.
module tb_zynq_axi_mem_responder;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          IW   = 6;
    localparam int          ELS  = 1024;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  id;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct {
        logic [5:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    zynq_axi_mem_responder_if #(.data_width_p(DW), .addr_width_p(AW), .id_width_p(IW)) bus ();

    zynq_axi_mem_responder #(
        .data_width_p(DW), .addr_width_p(AW), .id_width_p(IW), .els_p(ELS), .base_addr_p(BASE)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axi(bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_m [ELS];
    rbeat_t      rq[$];
    bexp_t       bq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level address map: word = (A - base) / 4; out-of-range either wraps or errs.
    task automatic map_addr(input logic [31:0] a, output int idx, output bit err);
        logic [31:0] w;
        w = (a - BASE) >> 2;
`ifdef ZYNQ_AXI_MEM_BOUNDS_CHECK_EN
        err = (w >= 32'(ELS));
`else
        err = 1'b0;
`endif
        idx = int'(w % 32'(ELS));
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        bit err;
        map_addr(a, idx, err);
        if (!err) begin
            for (int b = 0; b < 4; b++) if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Compare process: every cycle a response is presented it must match the queue head.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bus.rvalid) begin
                if (rq.size() == 0) check("r_unexpected", bus.rvalid, 1'b0);
                else begin
                    check("rdata", bus.rdata, rq[0].data);
                    check("rid", bus.rid, rq[0].id);
                    check("rresp", bus.rresp, rq[0].resp);
                    check("rlast", bus.rlast, rq[0].last);
                    if (bus.rready) void'(rq.pop_front());
                end
            end
            if (bus.bvalid) begin
                if (bq.size() == 0) check("b_unexpected", bus.bvalid, 1'b0);
                else begin
                    check("bid", bus.bid, bq[0].id);
                    check("bresp", bus.bresp, bq[0].resp);
                    if (bus.bready) void'(bq.pop_front());
                end
            end
        end
    end

    task automatic wait_ready(input int which, input string name);
        int   t;
        logic r;
        t = 0;
        do begin
            @(negedge aclk);
            r = (which == 0) ? bus.awready : (which == 1) ? bus.wready : bus.arready;
            t++;
        end while (!r && t < 500);
        if (!r) check(name, r, 1'b1);
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [5:0] id,
                             input logic [31:0] data[$], input logic [3:0] strb[$]);
        int    n, t, idx;
        bit    err, any_err, done;
        bexp_t eb;
        n = data.size();
        any_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            map_addr(addr + 32'(4 * k), idx, err);
            any_err |= err;
        end
        eb.id = id;
        eb.resp = any_err ? 2'b10 : 2'b00;
        bq.push_back(eb);
        bus.awaddr = addr; bus.awid = id; bus.awlen = 8'(n - 1); bus.awvalid = 1'b1;
        wait_ready(0, "aw_timeout");
        bus.awvalid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(3) == 0) begin
                bus.wvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            bus.wdata = data[k]; bus.wstrb = strb[k]; bus.wlast = (k == n - 1); bus.wvalid = 1'b1;
            wait_ready(1, "w_timeout");
            model_write(addr + 32'(4 * k), data[k], strb[k]);
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        t = 0;
        done = 1'b0;
        while (!done && t < 200) begin
            bus.bready = 1'($urandom_range(1));
            @(negedge aclk);
            done = bus.bvalid && bus.bready;
            @(posedge aclk);
            #1;
            t++;
        end
        bus.bready = 1'b0;
        if (!done) check("b_timeout", done, 1'b1);
    endtask

    function automatic logic rr_pat(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2) == 0;
        return 1'($urandom_range(1));
    endfunction

    task automatic axi_read(input logic [31:0] addr, input logic [5:0] id, input int n,
                            input int mode, output rbeat_t got[$]);
        int     c, t, idx;
        bit     err, done;
        rbeat_t eb;
        got.delete();
        for (int k = 0; k < n; k++) begin
            map_addr(addr + 32'(4 * k), idx, err);
            eb.data = err ? 32'h0 : mem_m[idx];
            eb.id = id;
            eb.resp = err ? 2'b10 : 2'b00;
            eb.last = (k == n - 1);
            rq.push_back(eb);
        end
        bus.araddr = addr; bus.arid = id; bus.arlen = 8'(n - 1); bus.arvalid = 1'b1;
        wait_ready(2, "ar_timeout");
        bus.arvalid = 1'b0;
        c = 0;
        bus.rready = rr_pat(mode, c);
        @(negedge aclk);
        check("r_latency", bus.rvalid, 1'b1);
        done = 1'b0;
        t = 0;
        while (!done && t < 2000) begin
            if (bus.rvalid && bus.rready) begin
                eb.data = bus.rdata; eb.id = bus.rid; eb.resp = bus.rresp; eb.last = bus.rlast;
                got.push_back(eb);
                done = bus.rlast || (got.size() >= n + 2);
            end
            @(posedge aclk);
            #1;
            c++;
            t++;
            bus.rready = done ? 1'b0 : rr_pat(mode, c);
            if (!done) @(negedge aclk);
        end
        bus.rready = 1'b0;
        if (!done) check("r_timeout", done, 1'b1);
    endtask

    task automatic check_all_idle_zero(input string tag);
        check({tag, "_awready"}, bus.awready, 1'b0);
        check({tag, "_wready"},  bus.wready,  1'b0);
        check({tag, "_bvalid"},  bus.bvalid,  1'b0);
        check({tag, "_arready"}, bus.arready, 1'b0);
        check({tag, "_rvalid"},  bus.rvalid,  1'b0);
        check({tag, "_rlast"},   bus.rlast,   1'b0);
        check({tag, "_bresp"},   bus.bresp,   2'b00);
        check({tag, "_rresp"},   bus.rresp,   2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dq[$];
        logic [3:0]  sq[$];
        rbeat_t      got[$];
        logic [31:0] addr;
        int          n;

        bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        repeat (3) @(negedge aclk);
        check_all_idle_zero("reset");
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("post_reset_awready", bus.awready, 1'b1);
        check("post_reset_arready", bus.arready, 1'b1);
        @(posedge aclk);
        #1;

        // Preload every word so the model never holds unknown contents.
        for (int blk = 0; blk < 4; blk++) begin
            dq.delete(); sq.delete();
            for (int k = 0; k < 256; k++) begin
                dq.push_back($urandom); sq.push_back(4'hF);
            end
            axi_write(32'(blk * 1024), 6'(blk), dq, sq);
        end

        // Single write then read back.
        dq = '{32'hDEADBEEF}; sq = '{4'hF};
        axi_write(32'h10, 6'd5, dq, sq);
        axi_read(32'h10, 6'd7, 1, 0, got);
        check("single_rdata", got[0].data, 32'hDEADBEEF);
        check("single_rlast", got[0].last, 1'b1);
        check("single_rresp", got[0].resp, 2'b00);

        // Partial strobe merges into existing word.
        dq = '{32'h11223344}; sq = '{4'hF};
        axi_write(32'h20, 6'd1, dq, sq);
        dq = '{32'hAABBCCDD}; sq = '{4'h5};
        axi_write(32'h20, 6'd2, dq, sq);
        axi_read(32'h20, 6'd3, 1, 0, got);
        check("strobe_merge", got[0].data, 32'h11BB33DD);

        // Four-beat burst read with rready toggling.
        dq = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003};
        sq = '{4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(32'h0, 6'd9, dq, sq);
        axi_read(32'h0, 6'd10, 4, 1, got);
        check("burst_beats", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            check("burst_data", got[k].data, 32'h10000000 + 32'(k));
            check("burst_last", got[k].last, k == 3);
        end

        // Address one word past the end of memory.
        axi_read(32'h1000, 6'd11, 1, 0, got);
`ifdef ZYNQ_AXI_MEM_BOUNDS_CHECK_EN
        check("oob_rdata", got[0].data, 32'h0);
        check("oob_rresp", got[0].resp, 2'b10);
`else
        check("oob_rdata", got[0].data, 32'h10000000);
        check("oob_rresp", got[0].resp, 2'b00);
`endif
        dq = '{32'h55555555}; sq = '{4'hF};
        axi_write(32'h1000, 6'd12, dq, sq);
        axi_read(32'h0, 6'd13, 1, 0, got);
`ifdef ZYNQ_AXI_MEM_BOUNDS_CHECK_EN
        check("oob_write_dropped", got[0].data, 32'h10000000);
`else
        check("oob_write_wrapped", got[0].data, 32'h55555555);
`endif

        // Reset in the middle of a four-beat write, after two beats.
        bus.awaddr = 32'h40; bus.awid = 6'd14; bus.awlen = 8'd3; bus.awvalid = 1'b1;
        wait_ready(0, "aw_timeout");
        bus.awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.wdata = 32'hB0000001 + 32'(k); bus.wstrb = 4'hF; bus.wvalid = 1'b1;
            wait_ready(1, "w_timeout");
            model_write(32'h40 + 32'(4 * k), 32'hB0000001 + 32'(k), 4'hF);
        end
        aresetn = 1'b0;
        bus.wvalid = 1'b0;
        #1;
        check_all_idle_zero("midreset");
        bq.delete();
        rq.delete();
        repeat (2) @(negedge aclk);
        check("midreset_no_bvalid", bus.bvalid, 1'b0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("release_awready", bus.awready, 1'b1);
        @(posedge aclk);
        #1;
        axi_read(32'h40, 6'd15, 4, 0, got);
        check("kept_beat1", got[0].data, 32'hB0000001);
        check("kept_beat2", got[1].data, 32'hB0000002);

        // Randomized mix, including addresses past the end of memory.
        for (int i = 0; i < 80; i++) begin
            addr = 32'($urandom_range(0, ELS + 63)) * 32'd4 + 32'($urandom_range(0, 3));
            n = $urandom_range(1, 8);
            if ($urandom_range(1) == 1) begin
                dq.delete(); sq.delete();
                for (int k = 0; k < n; k++) begin
                    dq.push_back($urandom); sq.push_back(4'($urandom_range(15)));
                end
                axi_write(addr, 6'($urandom_range(63)), dq, sq);
            end else begin
                axi_read(addr, 6'($urandom_range(63)), n, 2, got);
                check("rand_beats", got.size(), n);
            end
        end

        repeat (5) @(negedge aclk);
        check("rq_drained", rq.size(), 0);
        check("bq_drained", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
